// File: rtl/serial_parity_checker_pkg.sv
// rtl/serial_parity_checker_pkg.sv - shared types and defaults for the serial parity checker
package parity_pkg;

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_PAR  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam int             DEF_DATA_W      = 9;
    localparam logic [8:0]     DEF_PARITY_MASK = 9'h1EF;
    localparam int             ERRCNT_W        = 8;

endpackage

// File: rtl/serial_parity_checker_if.sv
// rtl/serial_parity_checker_if.sv - serial input beat stream and frame result stream
interface serial_parity_checker_if #(
    parameter int DATA_W = 9
);
    logic              in_valid;
    logic              in_bit;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/parity_fold.sv
// rtl/parity_fold.sv - combinational masked XOR reduction of a data word
module parity_fold #(
    parameter int              DATA_W      = 9,
    parameter logic [DATA_W-1:0] PARITY_MASK = 9'h1EF
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);
    assign parity = ^(data & PARITY_MASK);
endmodule

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - deserialise LSB-first frames and check masked parity; PAR_ERRCNT_EN adds err_count
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter logic [DATA_W-1:0] PARITY_MASK = DEF_PARITY_MASK,
    parameter bit                ODD         = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    serial_parity_checker_if.slave bus
`ifdef PAR_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]    err_count
`endif
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              acc;
    logic [DATA_W-1:0] shift;
    logic              beat;
    logic              last_data;
    logic              par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_DATA;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = (state != S_HOLD);
        beat         = bus.in_valid && bus.in_ready;
        last_data    = (cnt == CNT_W'(DATA_W - 1));
        par_err      = bus.in_bit ^ acc ^ ODD;
        case (state)
            S_DATA:  if (beat && last_data) state_nxt = S_PAR;
            S_PAR:   if (beat) state_nxt = S_HOLD;
            S_HOLD:  if (bus.out_valid && bus.out_ready) state_nxt = S_DATA;
            default: state_nxt = S_DATA;
        endcase
        if (flush) state_nxt = S_DATA;
    end

    // Bits arrive LSB-first, so shifting in from the top leaves bit 0 at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            acc           <= 1'b0;
            shift         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_err   <= 1'b0;
        end else if (flush) begin
            cnt           <= '0;
            acc           <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                S_DATA: if (beat) begin
                    shift <= {bus.in_bit, shift[DATA_W-1:1]};
                    acc   <= acc ^ (bus.in_bit & PARITY_MASK[cnt]);
                    cnt   <= last_data ? '0 : cnt + 1'b1;
                end
                S_PAR: if (beat) begin
                    bus.out_err   <= par_err;
                    bus.out_data  <= shift;
                    bus.out_valid <= 1'b1;
                    acc           <= 1'b0;
                end
                S_HOLD: if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef PAR_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (!flush && state == S_PAR && beat && par_err && err_count != '1)
            err_count <= err_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - directed self-checking bench for serial_parity_checker
module tb_serial_parity_checker;
    import parity_pkg::*;

    localparam int         W    = 9;
    localparam logic [8:0] MASK = 9'h1EF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush_o = 1'b0;
    logic [W-1:0] fold_in = '0;
    logic fold_par;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
`ifdef PAR_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count;
    logic [ERRCNT_W-1:0] err_count_o;
`endif

    serial_parity_checker_if #(.DATA_W(W)) bus ();
    serial_parity_checker_if #(.DATA_W(W)) bus_o ();

    serial_parity_checker #(.DATA_W(W), .PARITY_MASK(MASK), .ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave)
`ifdef PAR_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    serial_parity_checker #(.DATA_W(W), .PARITY_MASK(MASK), .ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .flush(flush_o), .bus(bus_o.slave)
`ifdef PAR_ERRCNT_EN
        , .err_count(err_count_o)
`endif
    );

    parity_fold #(.DATA_W(W), .PARITY_MASK(MASK)) gold (.data(fold_in), .parity(fold_par));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send_beat(input logic b);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++; fails++;
            $display("FAIL beat_timeout: in_ready stayed %0b, required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic p);
        for (int i = 0; i < W; i++) send_beat(d[i]);
        send_beat(p);
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [W-1:0] d, input logic e);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.out_err !== e) begin
            fails++;
            $display("FAIL %s: valid=%0b data=%h err=%0b, required valid=1 data=%h err=%0b",
                     name, bus.out_valid, bus.out_data, bus.out_err, d, e);
        end
    endtask

    task automatic check_fold(input logic [W-1:0] d, input logic p);
        fold_in = d;
        #1;
        tests++;
        if (fold_par !== p) begin
            fails++;
            $display("FAIL fold_%h: parity=%0b, required %0b", d, fold_par, p);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b0;
        bus_o.in_valid = 1'b0; bus_o.in_bit = 1'b0; bus_o.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%0b data=%h err=%0b, required 0/000/0",
                     bus.out_valid, bus.out_data, bus.out_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: %0b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        check_fold(9'h001, 1'b1);
        for (int i = 0; i < W; i++) send_beat(i == 0);
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_valid: %0b before parity beat, required 0", bus.out_valid);
        end
        send_beat(1'b1);
        check_frame("basic_001", 9'h001, 1'b0);
        handoff();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 9'h001) begin
            fails++;
            $display("FAIL after_handoff: valid=%0b data=%h, required 0/001", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_mask();
        check_fold(9'h010, 1'b0);
        send_frame(9'h010, 1'b0);
        check_frame("mask_010_p0", 9'h010, 1'b0);
        handoff();
        send_frame(9'h010, 1'b1);
        check_frame("mask_010_p1", 9'h010, 1'b1);
        handoff();
        check_fold(9'h1FF, 1'b0);
        send_frame(9'h1FF, 1'b0);
        check_frame("ones_1ff_p0", 9'h1FF, 1'b0);
        handoff();
    endtask

    task automatic test_odd();
        logic [W-1:0] d;
        d = 9'h1FF;
        for (int i = 0; i <= W; i++) begin
            bus_o.in_valid = 1'b1;
            bus_o.in_bit   = (i < W) ? d[i] : 1'b0;
            @(negedge clk);
        end
        bus_o.in_valid = 1'b0;
        tests++;
        if (bus_o.out_valid !== 1'b1 || bus_o.out_data !== 9'h1FF || bus_o.out_err !== 1'b1) begin
            fails++;
            $display("FAIL odd_1ff: valid=%0b data=%h err=%0b, required 1/1ff/1",
                     bus_o.out_valid, bus_o.out_data, bus_o.out_err);
        end
        bus_o.out_ready = 1'b1;
        @(negedge clk);
        bus_o.out_ready = 1'b0;
        d = 9'h001;
        for (int i = 0; i <= W; i++) begin
            bus_o.in_valid = 1'b1;
            bus_o.in_bit   = (i < W) ? d[i] : 1'b0;
            @(negedge clk);
        end
        bus_o.in_valid = 1'b0;
        tests++;
        if (bus_o.out_valid !== 1'b1 || bus_o.out_data !== 9'h001 || bus_o.out_err !== 1'b0) begin
            fails++;
            $display("FAIL odd_001: valid=%0b data=%h err=%0b, required 1/001/0",
                     bus_o.out_valid, bus_o.out_data, bus_o.out_err);
        end
    endtask

    task automatic test_hold();
        send_frame(9'h155, 1'b0);
        check_frame("hold_155", 9'h155, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 9'h155 || bus.out_err !== 1'b0) begin
                fails++;
                $display("FAIL hold_cycle%0d: ready=%0b valid=%0b data=%h err=%0b, required 0/1/155/0",
                         i, bus.in_ready, bus.out_valid, bus.out_data, bus.out_err);
            end
        end
        bus.in_valid = 1'b0;
        handoff();
        send_frame(9'h0AA, 1'b0);
        check_frame("after_hold_0aa", 9'h0AA, 1'b0);
        handoff();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) send_beat(1'b1);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check_fold(9'h0A5, 1'b0);
        send_frame(9'h0A5, 1'b0);
        check_frame("flush_0a5", 9'h0A5, 1'b0);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.out_ready = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_hold: valid=%0b ready=%0b, required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) send_beat(1'b1);
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: valid=%0b data=%h err=%0b, required 0/000/0",
                     bus.out_valid, bus.out_data, bus.out_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(9'h001, 1'b1);
        check_frame("post_reset_001", 9'h001, 1'b0);
        handoff();
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        bus.out_ready = 1'b1;
        send_frame(9'h155, 1'b0);
        check_frame("b2b_155", 9'h155, 1'b0);
        t0 = cyc;
        send_frame(9'h0AA, 1'b1);
        check_frame("b2b_0aa", 9'h0AA, 1'b1);
        t1 = cyc;
        bus.out_ready = 1'b0;
        tests++;
        if (t1 - t0 != W + 2) begin
            fails++;
            $display("FAIL b2b_period: %0d cycles, required %0d", t1 - t0, W + 2);
        end
        @(negedge clk);
    endtask

`ifdef PAR_ERRCNT_EN
    task automatic test_errcnt();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (err_count !== 8'd0) begin
            fails++;
            $display("FAIL errcnt_reset: %0d, required 0", err_count);
        end
        bus.out_ready = 1'b1;
        send_frame(9'h001, 1'b0);
        tests++;
        if (err_count !== 8'd1) begin
            fails++;
            $display("FAIL errcnt_one: %0d, required 1", err_count);
        end
        for (int i = 0; i < W; i++) send_beat(i == 0);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        tests++;
        if (err_count !== 8'd1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL errcnt_flush: count=%0d valid=%0b, required 1/0", err_count, bus.out_valid);
        end
        for (int i = 0; i < 300; i++) send_frame(9'h001, 1'b0);
        tests++;
        if (err_count !== 8'd255) begin
            fails++;
            $display("FAIL errcnt_saturate: %0d, required 255", err_count);
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_odd();
        test_hold();
        test_flush();
        test_reset_mid();
        test_back_to_back();
`ifdef PAR_ERRCNT_EN
        test_errcnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Receive end of the 9-bit masked-parity link: parity generator output is serialised as data bits LSB-first followed by one parity bit.
- Block deserialises each frame over a valid/ready stream, recomputes masked parity, and presents data plus an error flag on an output valid/ready stream.
- Sits between the serial link and the downstream consumer; it is the check/decode side for the combinational parity generator.

Parameters:
- DATA_W, 9, data bits per frame (frame length = DATA_W+1 beats).
- PARITY_MASK, 9'h1EF, bit k=1 means data bit k contributes to parity; default excludes bit 4.
- ODD, 0, 0 = even parity (parity bit = XOR of masked bits); 1 = odd parity (inverted).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of partial frame and pending output.
- in_valid  in  1  serial beat valid.
- in_bit  in  1  serial beat value.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts result when out_valid && out_ready.
- out_data  out  DATA_W  received data word.
- out_err  out  1  1 = parity mismatch.
- err_count  out  8  saturating error count (only with PAR_ERRCNT_EN).

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=S_DATA, bit counter=0, accumulator=0, shift reg=0, out_valid=0, out_data=0, out_err=0, err_count=0; in_ready=1 after reset release.
- FSM states:
  - S_DATA: in_ready=1. An accepted beat writes in_bit to data position cnt and XORs (in_bit & PARITY_MASK[cnt]) into acc. cnt increments; on cnt==DATA_W-1, go to S_PAR with cnt=0.
  - S_PAR: in_ready=1. An accepted beat computes out_err = in_bit ^ acc ^ ODD, loads out_data, sets out_valid=1, clears acc, and goes to S_HOLD.
  - S_HOLD: in_ready=0 and outputs stable. On out_valid && out_ready: out_valid=0 next cycle, go to S_DATA.
- Latency: out_valid rises the cycle after the parity beat is accepted. Throughput is one frame per DATA_W+2 cycles with continuous valid/ready.
- No-beat cycles (in_valid=0) leave state, cnt and acc unchanged; bubbles anywhere in a frame are legal.
- out_data/out_err hold until handoff; they are not cleared on handoff.
- flush=1: next state S_DATA, cnt=0, acc=0, out_valid=0. Flush wins over a simultaneous beat accept or output handoff, and the flushed frame does not update err_count.
- Reset mid-frame: immediate return to reset values; partial frame is lost.
- Masked bit positions (PARITY_MASK[k]=0) are still captured in out_data but never affect out_err.

Optional Feature:
- Macro PAR_ERRCNT_EN.
- Defined: err_count port exists. It increments by 1 on each S_PAR→S_HOLD transition with out_err=1, saturates at 255, and is cleared only by rst_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package parity_pkg holds:
  - state typedef (S_DATA, S_PAR, S_HOLD);
  - localparams DEF_DATA_W=9, DEF_PARITY_MASK=9'h1EF;
  - ERRCNT_W=8.
- One sub-module, parity_fold: combinational masked XOR reduction of a DATA_W word. The bench uses it as the golden model; the RTL does not need it, since it accumulates serially.

Test Plan:
- Reset then frame data 9'h001, parity 1 (even) → out_valid 1 cycle after parity beat, out_data=9'h001, out_err=0.
- Data 9'h010, parity 0 → out_err=0 (bit 4 masked); same data with parity 1 → out_err=1.
- Data 9'h1FF, parity 0 → out_err=0; with ODD=1 build, same frame → out_err=1.
- out_ready held 0 for 5 cycles in S_HOLD while in_valid=1 → in_ready=0, outputs stable, no beats lost; next frame accepted after handoff.
- flush asserted after 4 data beats, then full frame 9'h0A5 with correct parity → out_data=9'h0A5, out_err=0; rst_n pulse mid-frame → all outputs 0.
- PAR_ERRCNT_EN: 300 consecutive bad-parity frames → err_count=255, no wrap; a flush during S_PAR of a bad frame → no increment.
